// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side bus bundle for ahb_sram_slave.
// Ports (slave view):
//   hsel, haddr[31:0], htrans[1:0], hwrite, hsize[2:0], hwdata[31:0], hready_in  -> inputs
//   hrdata[31:0], hreadyout, hresp                                             -> outputs
interface ahb_sram_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_in;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with a two-phase address/data pipeline, byte lanes,
// configurable wait states, OKAY/ERROR responses, write-to-read forwarding
// and a byte-wide boot-load port.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   bus          AHB-Lite slave modport (see ahb_sram_slave_if)
//   boot_wr_en   boot byte write strobe (ignored when BOOT_EN=0)
//   boot_wr_addr boot byte address
//   boot_wr_data boot byte data
module ahb_sram_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0,
  parameter int READ_ONLY   = 0,
  parameter int BOOT_EN     = 1
) (
  input  logic              clk,
  input  logic              reset,
  ahb_sram_slave_if.slave   bus,
  input  logic              boot_wr_en,
  input  logic [31:0]       boot_wr_addr,
  input  logic [7:0]        boot_wr_data
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  function automatic logic [3:0] lane_strb(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    lane_strb = 4'b0001 << a;
      3'd1:    lane_strb = 4'b0011 << a;
      default: lane_strb = 4'b1111;
    endcase
  endfunction

  state_t         state, next;
  logic [2:0]     cnt;
  logic           rdy;
  logic           acc, acc_ok, a_err;
  logic [IW-1:0]  a_idx;
  logic [3:0]     a_strb;
  logic           boot_act, boot_in_range;
  logic           commit, do_read, rd_defer;
  logic [IW-1:0]  rd_idx;
  logic [31:0]    rd_word;
  logic [31:0]    hrdata_q;
  logic           wr_en;
  logic [IW-1:0]  wr_idx;
  logic [3:0]     wr_strb;
  logic [31:0]    wr_data;
  logic           unused;

  // data-phase registers
  logic           vld_p1;
  logic           write_p1;
  logic [IW-1:0]  idx_p1;
  logic [3:0]     strb_p1;

  logic [31:0]    mem [DEPTH_WORDS];

  assign unused = bus.htrans[0];

  assign boot_act      = (BOOT_EN != 0) && boot_wr_en;
  assign boot_in_range = boot_wr_addr[31:2] < 30'(DEPTH_WORDS);

  assign a_idx  = bus.haddr[IW+1:2];
  assign a_strb = lane_strb(bus.hsize, bus.haddr[1:0]);
  assign a_err  = (bus.hsize > 3'd2)
               || ((bus.hsize == 3'd1) && bus.haddr[0])
               || ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00))
               || (bus.haddr[31:2] >= 30'(DEPTH_WORDS))
               || (bus.hwrite && (READ_ONLY != 0));

  // Ready: a write data phase that collides with a boot write is stretched
  // combinationally; a read that collided at accept is stretched via rd_defer.
  always_comb begin
    rdy = 1'b1;
    case (state)
      IDLE:    rdy = !rd_defer && !(vld_p1 && write_p1 && boot_act);
      WAIT:    rdy = 1'b0;
      ERR1:    rdy = 1'b0;
      ERR2:    rdy = 1'b1;
      default: rdy = 1'b1;
    endcase
  end

  assign acc    = bus.hsel && bus.htrans[1] && bus.hready_in && rdy;
  assign acc_ok = acc && !a_err;

  always_comb begin
    next = state;
    case (state)
      IDLE, ERR2: begin
        next = IDLE;
        if (acc) begin
          if (a_err)                next = ERR1;
          else if (WAIT_STATES > 0) next = WAIT;
        end
      end
      WAIT:    next = (cnt <= 3'd1) ? IDLE : WAIT;
      ERR1:    next = ERR2;
      default: next = IDLE;
    endcase
  end

  assign bus.hreadyout = rdy;
  assign bus.hresp     = (state == ERR1) || (state == ERR2);
  assign bus.hrdata    = hrdata_q;

  assign commit  = (state == IDLE) && vld_p1 && write_p1 && !boot_act;
  assign do_read = !boot_act && (rd_defer || (acc_ok && !bus.hwrite));
  assign rd_idx  = rd_defer ? idx_p1 : a_idx;

  // Forward bytes being committed on this same edge into the read result.
  always_comb begin
    rd_word = mem[rd_idx];
    if (commit && (idx_p1 == rd_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_p1[b]) rd_word[8*b +: 8] = bus.hwdata[8*b +: 8];
      end
    end
  end

  // Single memory write port; boot wins over the AHB commit.
  always_comb begin
    wr_en   = commit;
    wr_idx  = idx_p1;
    wr_strb = strb_p1;
    wr_data = bus.hwdata;
    if (boot_act) begin
      wr_en   = boot_in_range;
      wr_idx  = boot_wr_addr[IW+1:2];
      wr_strb = 4'b0001 << boot_wr_addr[1:0];
      wr_data = {4{boot_wr_data}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      vld_p1   <= 1'b0;
      rd_defer <= 1'b0;
      hrdata_q <= 32'd0;
    end else begin
      state <= next;
      if (acc_ok)          cnt <= 3'(WAIT_STATES);
      else if (cnt != 3'd0) cnt <= cnt - 3'd1;
      if (acc)             vld_p1 <= !a_err;
      else if (rdy)        vld_p1 <= 1'b0;
      if (acc_ok && !bus.hwrite && boot_act) rd_defer <= 1'b1;
      else if (!boot_act)                    rd_defer <= 1'b0;
      if (do_read) hrdata_q <= rd_word;
    end
  end

  // ---- address phase -> data phase (p1) ----
  always_ff @(posedge clk) begin
    if (acc_ok) begin
      write_p1 <= bus.hwrite;
      idx_p1   <= a_idx;
      strb_p1  <= a_strb;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances (zero-wait RAM,
// two-wait RAM, ROM) share the stimulus; "cur" picks the active one.
module tb_ahb_sram_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        boot_wr_en;
  logic [31:0] boot_wr_addr;
  logic [7:0]  boot_wr_data;
  int          cur;
  logic [31:0] hrdata;
  logic        hreadyout, hresp;
  int          tests, fails;

  ahb_sram_slave_if if0 ();
  ahb_sram_slave_if if1 ();
  ahb_sram_slave_if if2 ();

  assign if0.hsel = hsel && (cur == 0);
  assign if0.haddr = haddr;
  assign if0.htrans = htrans;
  assign if0.hwrite = hwrite;
  assign if0.hsize = hsize;
  assign if0.hwdata = hwdata;
  assign if0.hready_in = if0.hreadyout;

  assign if1.hsel = hsel && (cur == 1);
  assign if1.haddr = haddr;
  assign if1.htrans = htrans;
  assign if1.hwrite = hwrite;
  assign if1.hsize = hsize;
  assign if1.hwdata = hwdata;
  assign if1.hready_in = if1.hreadyout;

  assign if2.hsel = hsel && (cur == 2);
  assign if2.haddr = haddr;
  assign if2.htrans = htrans;
  assign if2.hwrite = hwrite;
  assign if2.hsize = hsize;
  assign if2.hwdata = hwdata;
  assign if2.hready_in = if2.hreadyout;

  ahb_sram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .READ_ONLY(0), .BOOT_EN(1)) dut0 (
    .clk(clk), .reset(reset), .bus(if0), .boot_wr_en(boot_wr_en && (cur == 0)),
    .boot_wr_addr(boot_wr_addr), .boot_wr_data(boot_wr_data));
  ahb_sram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .READ_ONLY(0), .BOOT_EN(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1), .boot_wr_en(boot_wr_en && (cur == 1)),
    .boot_wr_addr(boot_wr_addr), .boot_wr_data(boot_wr_data));
  ahb_sram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .READ_ONLY(1), .BOOT_EN(1)) dut2 (
    .clk(clk), .reset(reset), .bus(if2), .boot_wr_en(boot_wr_en && (cur == 2)),
    .boot_wr_addr(boot_wr_addr), .boot_wr_data(boot_wr_data));

  always_comb begin
    case (cur)
      1:       begin hrdata = if1.hrdata; hreadyout = if1.hreadyout; hresp = if1.hresp; end
      2:       begin hrdata = if2.hrdata; hreadyout = if2.hreadyout; hresp = if2.hresp; end
      default: begin hrdata = if0.hrdata; hreadyout = if0.hreadyout; hresp = if0.hresp; end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addr(input logic [31:0] a, input logic wr, input logic [2:0] sz);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
  endtask

  task automatic drive_idle();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (hreadyout !== 1'b1 && n < 20) begin
      tick();
      #1;
      n++;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    int n;
    drive_addr(a, 1'b1, sz);
    tick();
    hwdata = d;
    drive_idle();
    #1;
    wait_ready(n);
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] sz, output int n);
    drive_addr(a, 1'b0, sz);
    tick();
    drive_idle();
    #1;
    wait_ready(n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      cur = i;
      #1;
      tests++;
      if ({hreadyout, hresp} !== 2'b10) begin
        fails++; $display("FAIL reset_ctl dut%0d: got %b want 10", i, {hreadyout, hresp});
      end
      tests++;
      if (hrdata !== 32'd0) begin
        fails++; $display("FAIL reset_rdata dut%0d: got %h want 00000000", i, hrdata);
      end
    end
    cur = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    cur = 0;
    drive_addr(32'h10, 1'b1, 3'd2);
    tick();
    hwdata = 32'hDEADBEEF;
    drive_addr(32'h10, 1'b0, 3'd2);
    #1;
    tests++;
    if (hreadyout !== 1'b1) begin fails++; $display("FAIL b2b_wr_ready: got %b want 1", hreadyout); end
    tick();
    drive_idle();
    #1;
    tests++;
    if ({hreadyout, hresp} !== 2'b10) begin fails++; $display("FAIL b2b_rd_ctl: got %b want 10", {hreadyout, hresp}); end
    tests++;
    if (hrdata !== 32'hDEADBEEF) begin fails++; $display("FAIL b2b_rdata: got %h want deadbeef", hrdata); end
    tick();
  endtask

  task automatic test_byte_lanes();
    int n;
    drive_addr(32'h13, 1'b1, 3'd0);
    tick();
    hwdata = 32'hAA000000;
    drive_addr(32'h10, 1'b0, 3'd2);
    tick();
    drive_idle();
    #1;
    tests++;
    if (hrdata !== 32'hAAADBEEF) begin fails++; $display("FAIL byte_fwd: got %h want aaadbeef", hrdata); end
    tick();
    do_read(32'h12, 3'd0, n);
    tests++;
    if (hrdata !== 32'hAAADBEEF) begin fails++; $display("FAIL byte_read_lanes: got %h want aaadbeef", hrdata); end
    tick();
    // boot write during a write data phase stretches it by one cycle
    drive_addr(32'h8, 1'b1, 3'd2);
    tick();
    hwdata = 32'hA1B2C3D4;
    drive_idle();
    boot_wr_en = 1'b1; boot_wr_addr = 32'hC; boot_wr_data = 8'hEE;
    #1;
    tests++;
    if (hreadyout !== 1'b0) begin fails++; $display("FAIL boot_stretch_wr: got %b want 0", hreadyout); end
    tick();
    boot_wr_en = 1'b0;
    #1;
    tests++;
    if (hreadyout !== 1'b1) begin fails++; $display("FAIL boot_stretch_end: got %b want 1", hreadyout); end
    tick();
    do_read(32'h8, 3'd2, n);
    tests++;
    if (hrdata !== 32'hA1B2C3D4) begin fails++; $display("FAIL boot_stretch_commit: got %h want a1b2c3d4", hrdata); end
    do_read(32'hC, 3'd2, n);
    tests++;
    if (hrdata[7:0] !== 8'hEE) begin fails++; $display("FAIL boot_byte: got %h want ee", hrdata[7:0]); end
    tick();
  endtask

  task automatic test_wait_states();
    int n;
    cur = 1;
    drive_addr(32'h20, 1'b1, 3'd2);
    tick();
    hwdata = 32'h12345678;
    drive_idle();
    #1;
    tests++;
    if (hreadyout !== 1'b0) begin fails++; $display("FAIL ws_wr_stall: got %b want 0", hreadyout); end
    wait_ready(n);
    tests++;
    if (n !== 2) begin fails++; $display("FAIL ws_wr_waits: got %0d want 2", n); end
    drive_addr(32'h20, 1'b0, 3'd2);
    tick();
    drive_idle();
    #1;
    wait_ready(n);
    tests++;
    if (n !== 2) begin fails++; $display("FAIL ws_rd_waits: got %0d want 2", n); end
    tests++;
    if ({hrdata, hresp} !== {32'h12345678, 1'b0}) begin
      fails++; $display("FAIL ws_rdata: got %h/%b want 12345678/0", hrdata, hresp);
    end
    tick();
  endtask

  task automatic test_errors();
    int n;
    cur = 0;
    do_write(32'h0, 32'h11223344, 3'd2);
    do_read(32'h0, 3'd2, n);
    tick();
    drive_addr(32'h21, 1'b0, 3'd1);
    tick();
    drive_idle();
    #1;
    tests++;
    if ({hresp, hreadyout} !== 2'b10) begin fails++; $display("FAIL err_half_c1: got %b want 10", {hresp, hreadyout}); end
    tick();
    tests++;
    if ({hresp, hreadyout} !== 2'b11) begin fails++; $display("FAIL err_half_c2: got %b want 11", {hresp, hreadyout}); end
    tests++;
    if (hrdata !== 32'h11223344) begin fails++; $display("FAIL err_hold_rdata: got %h want 11223344", hrdata); end
    tick();
    tests++;
    if ({hresp, hreadyout} !== 2'b01) begin fails++; $display("FAIL err_half_done: got %b want 01", {hresp, hreadyout}); end
    drive_addr(32'h1000, 1'b1, 3'd2);
    tick();
    hwdata = 32'hFFFFFFFF;
    drive_idle();
    #1;
    tests++;
    if ({hresp, hreadyout} !== 2'b10) begin fails++; $display("FAIL err_oor_c1: got %b want 10", {hresp, hreadyout}); end
    tick();
    tests++;
    if ({hresp, hreadyout} !== 2'b11) begin fails++; $display("FAIL err_oor_c2: got %b want 11", {hresp, hreadyout}); end
    tick();
    do_read(32'h0, 3'd2, n);
    tests++;
    if (hrdata !== 32'h11223344) begin fails++; $display("FAIL err_mem_kept: got %h want 11223344", hrdata); end
    drive_addr(32'h0, 1'b0, 3'd3);
    tick();
    drive_idle();
    #1;
    tests++;
    if (hresp !== 1'b1) begin fails++; $display("FAIL err_size3: got %b want 1", hresp); end
    tick();
    tick();
  endtask

  task automatic test_rom_boot();
    int n;
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h55;
    cur = 2;
    for (int i = 0; i < 4; i++) begin
      boot_wr_en = 1'b1; boot_wr_addr = 32'(4 + i); boot_wr_data = bytes[i];
      tick();
    end
    boot_wr_en = 1'b0;
    do_read(32'h4, 3'd2, n);
    tests++;
    if (hrdata[31:24] !== 8'h55) begin fails++; $display("FAIL rom_boot_byte: got %h want 55", hrdata[31:24]); end
    tests++;
    if (hrdata !== 32'h55332211) begin fails++; $display("FAIL rom_boot_word: got %h want 55332211", hrdata); end
    tick();
    drive_addr(32'h4, 1'b1, 3'd2);
    tick();
    hwdata = 32'h0;
    drive_idle();
    #1;
    tests++;
    if ({hresp, hreadyout} !== 2'b10) begin fails++; $display("FAIL rom_wr_err: got %b want 10", {hresp, hreadyout}); end
    tick();
    tick();
    do_read(32'h4, 3'd2, n);
    tests++;
    if (hrdata !== 32'h55332211) begin fails++; $display("FAIL rom_unchanged: got %h want 55332211", hrdata); end
    tick();
    // read accepted on the same edge as a boot write to the same word
    drive_addr(32'h4, 1'b0, 3'd2);
    boot_wr_en = 1'b1; boot_wr_addr = 32'h4; boot_wr_data = 8'h66;
    tick();
    boot_wr_en = 1'b0;
    drive_idle();
    #1;
    tests++;
    if (hreadyout !== 1'b0) begin fails++; $display("FAIL boot_rd_stretch: got %b want 0", hreadyout); end
    tick();
    tests++;
    if ({hreadyout, hrdata} !== {1'b1, 32'h55332266}) begin
      fails++; $display("FAIL boot_rd_data: got %b/%h want 1/55332266", hreadyout, hrdata);
    end
    boot_wr_en = 1'b1; boot_wr_addr = 32'h1004; boot_wr_data = 8'h77;
    tick();
    boot_wr_en = 1'b0;
    do_read(32'h4, 3'd2, n);
    tests++;
    if (hrdata !== 32'h55332266) begin fails++; $display("FAIL boot_oor_drop: got %h want 55332266", hrdata); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    int n;
    cur = 1;
    do_write(32'h30, 32'hCAFEF00D, 3'd2);
    drive_addr(32'h30, 1'b1, 3'd2);
    tick();
    hwdata = 32'h0;
    drive_idle();
    #1;
    tests++;
    if (hreadyout !== 1'b0) begin fails++; $display("FAIL rst_mid_stall: got %b want 0", hreadyout); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    tests++;
    if ({hreadyout, hresp} !== 2'b10) begin fails++; $display("FAIL rst_mid_ctl: got %b want 10", {hreadyout, hresp}); end
    do_read(32'h30, 3'd2, n);
    tests++;
    if (n !== 2) begin fails++; $display("FAIL rst_mid_waits: got %0d want 2", n); end
    tests++;
    if (hrdata !== 32'hCAFEF00D) begin fails++; $display("FAIL rst_mid_kept: got %h want cafef00d", hrdata); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tests = 0; fails = 0; cur = 0;
    hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; hwdata = 32'h0;
    boot_wr_en = 1'b0; boot_wr_addr = 32'h0; boot_wr_data = 8'h0;
    reset = 1'b1;
    test_reset();
    test_back_to_back();
    test_byte_lanes();
    test_wait_states();
    test_errors();
    test_rom_boot();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
